// File: rtl/mem2_load_collector.sv
// MEM2-stage load response collector: formats the in-order data response,
// holds it until MEM2 advances, stalls while it is outstanding and drops
// the orphaned response of a flushed load.
module mem2_load_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM2_Flush,
  input  logic        MEM2_Wr,
  input  logic        MEM2_IsLoad,
  input  logic [1:0]  MEM2_LoadSize,
  input  logic        MEM2_LoadSign,
  input  logic [1:0]  MEM2_Offset,
  input  logic        Dres_valid,
  input  logic [31:0] Dres_data,
  output logic [31:0] MEM2_LoadData,
  output logic        MEM2_LoadValid,
  output logic        Load_Stall
);

  localparam int unsigned DataW = 32;
  localparam int unsigned ByteW = 8;
  localparam int unsigned HalfW = 16;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DONE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [DataW-1:0] load_buf;
  logic [DataW-1:0] formatted;
  logic             accept;

  // Extract the addressed field from the aligned word and extend it.
  function automatic logic [DataW-1:0] format_load(
    input logic [DataW-1:0] d,
    input logic [1:0]       size,
    input logic             sign,
    input logic [1:0]       offset
  );
    logic [ByteW-1:0] byte_f;
    logic [HalfW-1:0] half_f;
    logic [DataW-1:0] result;
    byte_f = d[ByteW-1:0];
    half_f = d[HalfW-1:0];
    result = d;
    case (offset)
      2'd0:    byte_f = d[7:0];
      2'd1:    byte_f = d[15:8];
      2'd2:    byte_f = d[23:16];
      default: byte_f = d[31:24];
    endcase
    half_f = offset[1] ? d[31:16] : d[15:0];
    if (size == SizeByte) begin
      result = {{(DataW-ByteW){sign & byte_f[ByteW-1]}}, byte_f};
    end else if (size == SizeHalf) begin
      result = {{(DataW-HalfW){sign & half_f[HalfW-1]}}, half_f};
    end
    return result;
  endfunction

  assign formatted = format_load(Dres_data, MEM2_LoadSize, MEM2_LoadSign, MEM2_Offset);
  assign accept    = (state == IDLE) && MEM2_IsLoad && Dres_valid;

  // Zero-latency outputs: the response is forwarded in its arrival cycle.
  always_comb begin
    MEM2_LoadData  = '0;
    MEM2_LoadValid = 1'b0;
    Load_Stall     = 1'b0;
    case (state)
      IDLE: begin
        if (MEM2_IsLoad) begin
          if (Dres_valid) begin
            MEM2_LoadData  = formatted;
            MEM2_LoadValid = 1'b1;
          end else begin
            Load_Stall = 1'b1;
          end
        end
      end
      DONE: begin
        MEM2_LoadData  = load_buf;
        MEM2_LoadValid = 1'b1;
      end
      DRAIN: begin
        Load_Stall = MEM2_IsLoad;
      end
      default: begin
        MEM2_LoadData = '0;
      end
    endcase
  end

  // State and held result; flush takes priority over MEM2_Wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            load_buf <= formatted;
            if (!MEM2_Flush && !MEM2_Wr) begin
              state <= DONE;
            end
          end else if (MEM2_IsLoad && MEM2_Flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (MEM2_Flush || MEM2_Wr) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (Dres_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem2_load_collector.md
# mem2_load_collector

Consumer side of the data-memory load path in the MEM2 stage. A load issues its data request in MEM; the response returns while the load sits in the MEM2 register. This block receives the in-order response and extracts and sign/zero-extends the addressed byte, halfword or word. It holds the formatted result until the pipeline advances, and raises a stall while the response is outstanding. After a flush it discards the orphaned response of a killed load.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  stage clock.
- rst  in  1  reset; synchronous, active-high.
- MEM2_Flush  in  1  kills the instruction currently in MEM2.
- MEM2_Wr  in  1  MEM2 register advances at this edge; the current load's result is consumed.
- MEM2_IsLoad  in  1  instruction in MEM2 is a load with a request already issued.
- MEM2_LoadSize  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- MEM2_LoadSign  in  1  1 sign-extend, 0 zero-extend.
- MEM2_Offset  in  2  address bits [1:0] (MEM2_ALUOut[1:0]).
- Dres_valid  in  1  one-cycle response strobe, in request order.
- Dres_data  in  32  raw aligned response word.
- MEM2_LoadData  out  32  formatted load result.
- MEM2_LoadValid  out  1  MEM2_LoadData is valid this cycle.
- Load_Stall  out  1  request to hazard unit: hold MEM2 and earlier stages.

## Operation
FSM with three states (reset → IDLE); data buffer `buf` (32 bits, reset 0).
- Format function F(d): byte = d[8*Offset+7 : 8*Offset]; halfword = d[31:16] if Offset[1] else d[15:0], with Offset[0] ignored (misalignment is excepted upstream); word = d. Extend to 32 bits per MEM2_LoadSign. Byte/half sign bit is the top bit of the extracted field.
- IDLE: no captured response for the current instruction.
  - MEM2_IsLoad & ~Dres_valid: Load_Stall=1, LoadValid=0.
  - MEM2_IsLoad & Dres_valid: LoadData=F(Dres_data) combinationally, LoadValid=1, Load_Stall=0. buf←F(Dres_data). If ~MEM2_Wr, go to DONE; otherwise stay in IDLE.
  - ~MEM2_IsLoad: Dres_valid is ignored (stray response) and outputs are 0.
- DONE: LoadData=buf, LoadValid=1, Load_Stall=0. MEM2_Wr → IDLE. Further Dres_valid is ignored.
- DRAIN: a killed load's response is still in flight.
  - First Dres_valid is dropped (buf unchanged). Go to IDLE.
  - Load_Stall = MEM2_IsLoad for the whole state, including the drop cycle. A new load cannot take the dropped response.
- Flush rules (priority over MEM2_Wr):
  - IDLE with MEM2_IsLoad & ~Dres_valid → DRAIN.
  - IDLE with Dres_valid in the same cycle → IDLE (response consumed, discarded).
  - DONE → IDLE.
  - DRAIN → DRAIN, or IDLE if Dres_valid in the same cycle.
- Outputs in IDLE without a response, and during DRAIN: LoadData=0, LoadValid=0.

## Timing
- Zero-cycle latency: LoadData and LoadValid respond combinationally to Dres_valid in the same cycle. All state and buf update at posedge clk.
- Load_Stall is combinational from state, MEM2_IsLoad and Dres_valid. It drops in the response cycle so MEM2_Wr can assert in that same cycle.
- rst has priority over everything. At the next edge: state=IDLE, buf=0, all outputs 0 (with MEM2_IsLoad=0).
- At most one response is outstanding per MEM2 occupant. A second Dres_valid for the same load is a protocol violation and is ignored in DONE.

## Test plan
- Word load, response two cycles after entry, Dres_data=0x8765_4321, size 10 → Load_Stall=1 for 2 cycles; LoadData=0x8765_4321 with LoadValid=1 in the response cycle.
- Signed byte, Offset=2, data=0x00F0_0000 → 0xFFFF_FFF0. Unsigned halfword, Offset=2, data=0x8001_1234 → 0x0000_8001.
- Response arrives with MEM2_Wr=0 for 3 cycles → state DONE; LoadData stable from buf; Load_Stall=0; IDLE after MEM2_Wr.
- Flush while waiting, new load enters next cycle → first Dres_valid (0xDEAD_BEEF) dropped with Load_Stall=1. Second response (0x0000_0011) is delivered to the new load.
- Flush coincident with Dres_valid → no DRAIN; the next load's first response is accepted.
- rst asserted in DONE and in DRAIN → IDLE, buf=0; the next response is accepted by a new load.
